// File: rtl/video_timing_pattern_gen_if.sv
// Video source bus: run/pattern controls in, registered timing and pixel stream out.
// Ports: en, cfg_mode, cfg_color (controls); hs, vs, de, rgb_r/g/b, pix_x, pix_y, sof, frame_cnt (video).
// master = generator side, slave = consumer/controller side.
interface video_timing_pattern_gen_if #(
  parameter int CNT_W = 12,
  parameter int DW    = 8
);
  logic              en;
  logic [1:0]        cfg_mode;
  logic [3*DW-1:0]   cfg_color;
  logic              hs;
  logic              vs;
  logic              de;
  logic [DW-1:0]     rgb_r;
  logic [DW-1:0]     rgb_g;
  logic [DW-1:0]     rgb_b;
  logic [CNT_W-1:0]  pix_x;
  logic [CNT_W-1:0]  pix_y;
  logic              sof;
  logic [15:0]       frame_cnt;

  modport master (
    input  en, cfg_mode, cfg_color,
    output hs, vs, de, rgb_r, rgb_g, rgb_b, pix_x, pix_y, sof, frame_cnt
  );

  modport slave (
    output en, cfg_mode, cfg_color,
    input  hs, vs, de, rgb_r, rgb_g, rgb_b, pix_x, pix_y, sof, frame_cnt
  );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Parametrised video timing generator with test-pattern source; every output registered, 1-cycle latency.
// Ports: clk (pixel clock), rst (async active-low), vid (master modport: en/cfg in, sync/de/rgb/coords/sof/frame_cnt out).
// No backpressure: free-running once started; stop requests take effect at the end of the current frame.
module video_timing_pattern_gen #(
  parameter int CNT_W    = 12,
  parameter int DW       = 8,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CHK_LOG2 = 5
) (
  input  logic clk,
  input  logic rst,
  video_timing_pattern_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] BAR_END = CNT_W'(8 * BAR_W);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t           state, state_nxt;
  logic             active;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             at_origin, at_end, de_c;
  logic [1:0]       mode_sh, mode_eff;
  logic [3*DW-1:0]  color_sh, color_eff;
  logic [2:0]       bar_idx, bar_rgb;
  logic [DW-1:0]    pat_r, pat_g, pat_b;

  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 3'b111;
      3'd1:    bar_color = 3'b110;
      3'd2:    bar_color = 3'b011;
      3'd3:    bar_color = 3'b010;
      3'd4:    bar_color = 3'b101;
      3'd5:    bar_color = 3'b100;
      3'd6:    bar_color = 3'b001;
      default: bar_color = 3'b000;
    endcase
  endfunction

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign de_c      = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (vid.en) state_nxt = RUN;
      RUN:       if (!vid.en) state_nxt = STOP_PEND;
      STOP_PEND: begin
        // A renewed run request wins over the end-of-frame stop.
        if (vid.en)      state_nxt = RUN;
        else if (at_end) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    active = 1'b0;
    case (state)
      RUN, STOP_PEND: active = 1'b1;
      default:        active = 1'b0;
    endcase
  end

  // ---------------- raster counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!active) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // ---------------- pattern config shadow ----------------
  // Captured at (0,0); the origin pixel itself already uses the live value,
  // so the whole frame sees one consistent configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sh  <= '0;
      color_sh <= '0;
    end else if (at_origin) begin
      mode_sh  <= vid.cfg_mode;
      color_sh <= vid.cfg_color;
    end
  end

  assign mode_eff  = at_origin ? vid.cfg_mode  : mode_sh;
  assign color_eff = at_origin ? vid.cfg_color : color_sh;

  // ---------------- pattern generation ----------------
  always_comb begin
    pat_r   = '0;
    pat_g   = '0;
    pat_b   = '0;
    bar_rgb = 3'b000;
    bar_idx = 3'(h_cnt / BAR_DIV);
    case (mode_eff)
      2'd0: begin
        // Pixels beyond the eighth bar (H_ACTIVE not a multiple of 8) stay black.
        if (h_cnt < BAR_END) bar_rgb = bar_color(bar_idx);
        pat_r = {DW{bar_rgb[2]}};
        pat_g = {DW{bar_rgb[1]}};
        pat_b = {DW{bar_rgb[0]}};
      end
      2'd1: begin
        pat_r = color_eff[3*DW-1:2*DW];
        pat_g = color_eff[2*DW-1:DW];
        pat_b = color_eff[DW-1:0];
      end
      2'd2: begin
        pat_r = h_cnt[DW-1:0];
        pat_g = h_cnt[DW-1:0];
        pat_b = h_cnt[DW-1:0];
      end
      default: begin
        pat_r = {DW{h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]}};
        pat_g = pat_r;
        pat_b = pat_r;
      end
    endcase
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid.hs    <= ~HS_POL;
      vid.vs    <= ~VS_POL;
      vid.de    <= 1'b0;
      vid.rgb_r <= '0;
      vid.rgb_g <= '0;
      vid.rgb_b <= '0;
      vid.pix_x <= '0;
      vid.pix_y <= '0;
      vid.sof   <= 1'b0;
    end else if (!active) begin
      vid.hs    <= ~HS_POL;
      vid.vs    <= ~VS_POL;
      vid.de    <= 1'b0;
      vid.rgb_r <= '0;
      vid.rgb_g <= '0;
      vid.rgb_b <= '0;
      vid.pix_x <= '0;
      vid.pix_y <= '0;
      vid.sof   <= 1'b0;
    end else begin
      vid.hs    <= ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
      vid.vs    <= ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
      vid.de    <= de_c;
      vid.rgb_r <= de_c ? pat_r : '0;
      vid.rgb_g <= de_c ? pat_g : '0;
      vid.rgb_b <= de_c ? pat_b : '0;
      vid.sof   <= at_origin;
      if (de_c) begin
        vid.pix_x <= h_cnt;
        vid.pix_y <= v_cnt;
      end
    end
  end

  // Counts frames whose last position has been emitted; holds through IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  vid.frame_cnt <= '0;
    else if (active && at_end) vid.frame_cnt <= vid.frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen in a 24x8 raster (H 16/2/3/3, V 4/1/2/1).
// Expected per-cycle output records are queued by the stimulus; a monitor aligns on sof and checks each cycle.
// Covers reset, timing, colour bars, solid, gradient, checkerboard, frame-aligned stop/restart, async reset.
module tb_video_timing_pattern_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] rgb;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  video_timing_pattern_gen_if #(.CNT_W(12), .DW(8)) vif ();

  video_timing_pattern_gen #(
    .CNT_W(12), .DW(8),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .vid(vif.master)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  bit          synced = 1'b0;
  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // One full frame of expected outputs, starting at the sof cycle.
  task automatic push_frame(input int mode, input logic [23:0] color, input int base);
    exp_t e;
    int   col, line, lx, ly;
    lx = 0;
    ly = 0;
    for (int c = 0; c < 192; c++) begin
      col  = c % 24;
      line = c / 24;
      e.de  = (col < 16) && (line < 4);
      e.hs  = (col >= 18) && (col < 21);
      e.vs  = (line >= 5) && (line < 7);
      e.sof = (c == 0);
      if (e.de) begin
        lx = col;
        ly = line;
      end
      e.x   = 12'(lx);
      e.y   = 12'(ly);
      e.rgb = 24'h0;
      if (e.de) begin
        case (mode)
          0:       e.rgb = bar_tbl[col / 2];
          1:       e.rgb = color;
          2:       e.rgb = {3{8'(col)}};
          default: e.rgb = ((((col >> 2) ^ (line >> 2)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        endcase
      end
      e.fc = 16'(base + ((c == 191) ? 1 : 0));
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (sampling just after posedge) until at most lim records remain queued.
  task automatic wait_q(input int lim, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (q.size() <= lim) return;
    end
    total++;
    bad++;
    $display("FAIL %s: timeout, %0d records still queued", name, q.size());
    q.delete();
  endtask

  // Monitor: locks onto sof while records are pending, then checks every cycle.
  always @(negedge clk) begin
    exp_t a, e;
    if (q.size() == 0) begin
      synced = 1'b0;
    end else begin
      if (!synced && vif.sof === 1'b1) synced = 1'b1;
      if (synced) begin
        e = q.pop_front();
        a = {vif.hs, vif.vs, vif.de, vif.sof, vif.pix_x, vif.pix_y,
             vif.rgb_r, vif.rgb_g, vif.rgb_b, vif.frame_cnt};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL stream: got hs%b vs%b de%b sof%b x%0d y%0d rgb%06h fc%0d expected hs%b vs%b de%b sof%b x%0d y%0d rgb%06h fc%0d",
                   a.hs, a.vs, a.de, a.sof, a.x, a.y, a.rgb, a.fc,
                   e.hs, e.vs, e.de, e.sof, e.x, e.y, e.rgb, e.fc);
        end
      end
    end
  end

  initial begin
    rst           = 1'b0;
    vif.en        = 1'b0;
    vif.cfg_mode  = 2'd0;
    vif.cfg_color = 24'h0;
    #12;
    chk("rst_hs", 32'(vif.hs), 32'h0);
    chk("rst_vs", 32'(vif.vs), 32'h0);
    chk("rst_de", 32'(vif.de), 32'h0);
    chk("rst_rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'h0);
    chk("rst_pix", 32'({vif.pix_x, vif.pix_y}), 32'h0);
    chk("rst_sof", 32'(vif.sof), 32'h0);
    chk("rst_fc", 32'(vif.frame_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_de", 32'(vif.de), 32'h0);
    chk("idle_hs", 32'(vif.hs), 32'h0);

    // Colour bars for two frames; mode 1 requested mid second frame applies from the third.
    push_frame(0, 24'h0, 0);
    push_frame(0, 24'h0, 1);
    push_frame(1, 24'h123456, 2);
    vif.en = 1'b1;
    @(posedge clk);
    #1 chk("start_edge1_de", 32'(vif.de), 32'h0);
    @(posedge clk);
    #1;
    chk("start_edge2_sof", 32'(vif.sof), 32'h1);
    chk("start_edge2_de", 32'(vif.de), 32'h1);
    repeat (288) @(posedge clk);
    #1;
    vif.cfg_mode  = 2'd1;
    vif.cfg_color = 24'h123456;
    wait_q(0, 700, "bars_then_solid");

    // Stop request during line 2: the frame completes, then IDLE.
    push_frame(1, 24'h123456, 3);
    repeat (50) @(posedge clk);
    #1 vif.en = 1'b0;
    wait_q(0, 400, "stop_frame");
    chk("stop_de", 32'(vif.de), 32'h0);
    chk("stop_hs", 32'(vif.hs), 32'h0);
    chk("stop_vs", 32'(vif.vs), 32'h0);
    chk("stop_sof", 32'(vif.sof), 32'h0);
    chk("stop_rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'h0);
    chk("stop_fc", 32'(vif.frame_cnt), 32'd4);
    repeat (30) @(posedge clk);
    #1;
    chk("idle_fc_hold", 32'(vif.frame_cnt), 32'd4);
    chk("idle_de_hold", 32'(vif.de), 32'h0);

    // Restart, then a brief stop request withdrawn while pending: no gap.
    push_frame(1, 24'h123456, 4);
    push_frame(1, 24'h123456, 5);
    push_frame(1, 24'h123456, 6);
    vif.en = 1'b1;
    repeat (70) @(posedge clk);
    #1 vif.en = 1'b0;
    repeat (20) @(posedge clk);
    #1 vif.en = 1'b1;
    wait_q(0, 700, "stop_pend_resume");

    // Checkerboard next frame, then gradient.
    push_frame(1, 24'h123456, 7);
    vif.cfg_mode = 2'd3;
    push_frame(3, 24'h0, 8);
    wait_q(192, 300, "to_checker");
    vif.cfg_mode = 2'd2;
    push_frame(2, 24'h0, 9);
    wait_q(0, 500, "checker_gradient");

    // Asynchronous reset in the middle of line 1.
    push_frame(2, 24'h0, 10);
    repeat (30) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_hs", 32'(vif.hs), 32'h0);
    chk("arst_vs", 32'(vif.vs), 32'h0);
    chk("arst_de", 32'(vif.de), 32'h0);
    chk("arst_rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'h0);
    chk("arst_pix", 32'({vif.pix_x, vif.pix_y}), 32'h0);
    chk("arst_fc", 32'(vif.frame_cnt), 32'h0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    push_frame(2, 24'h0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rerun_edge1_sof", 32'(vif.sof), 32'h0);
    @(posedge clk);
    #1;
    chk("rerun_edge2_sof", 32'(vif.sof), 32'h1);
    chk("rerun_fc", 32'(vif.frame_cnt), 32'h0);
    wait_q(0, 400, "rerun_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
